// File: rtl/tl_cntr_param_if.sv
// Signal bundle for the round-robin traffic-light controller: sensors in, lights and status out.
// The controller takes the slave view; the environment driving the sensors takes the master view.
interface tl_cntr_param_if #(
  parameter int NUM_DIR = 4
);
  logic [NUM_DIR-1:0]   T;
  logic [2*NUM_DIR-1:0] L;
  logic [2:0]           cur_dir;
  logic [1:0]           phase;

  modport master (output T, input L, cur_dir, phase);
  modport slave  (input T, output L, cur_dir, phase);
endinterface

// File: rtl/tl_cntr_param.sv
// Parameterised round-robin traffic-light controller for NUM_DIR approaches.
// Each green is followed by yellow and all-red phases, and all lights are decoded from registered state.
module tl_cntr_param #(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_MIN  = 3,
  parameter int GREEN_MAX  = 6,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          reset,
  tl_cntr_param_if.slave bus
);
  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;
  localparam logic [1:0] PH_ALLRED = 2'b10;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  logic [1:0]       phase_q, phase_d;
  logic [2:0]       cur_dir_q, cur_dir_d;
  logic [2:0]       nxt_dir_q, nxt_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_DIR-1:0] cur_oh;
  logic               demand;
  logic               own_req;
  logic [CNT_W:0]     dwell;
  logic [2:0]         rr_dir;
  logic               rr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_oh
      assign cur_oh[gi] = (cur_dir_q == 3'(gi));
    end
  endgenerate

  assign demand  = |(bus.T & ~cur_oh);
  assign own_req = |(bus.T & cur_oh);
  // One extra bit so the dwell of a saturated counter does not wrap to zero.
  assign dwell   = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // First requesting direction after cur_dir, wrapping past the last index.
  always_comb begin
    rr_dir = cur_dir_q;
    rr_hit = 1'b0;
    for (int k = 1; k < NUM_DIR; k++) begin
      if (!rr_hit && bus.T[(int'(cur_dir_q) + k) % NUM_DIR]) begin
        rr_hit = 1'b1;
        rr_dir = 3'((int'(cur_dir_q) + k) % NUM_DIR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_GREEN;
      cur_dir_q <= 3'd0;
      nxt_dir_q <= 3'd0;
      cnt_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      cur_dir_q <= cur_dir_d;
      nxt_dir_q <= nxt_dir_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cur_dir_d = cur_dir_q;
    nxt_dir_d = nxt_dir_q;
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    case (phase_q)
      PH_GREEN: begin
        if (demand && dwell >= (CNT_W+1)'(GREEN_MIN) &&
            (!own_req || dwell >= (CNT_W+1)'(GREEN_MAX))) begin
          phase_d   = PH_YELLOW;
          nxt_dir_d = rr_dir;
        end
      end
      PH_YELLOW: begin
        if (dwell == (CNT_W+1)'(YELLOW_CYC)) begin
          phase_d = PH_ALLRED;
        end
      end
      PH_ALLRED: begin
        if (dwell == (CNT_W+1)'(ALLRED_CYC)) begin
          phase_d   = PH_GREEN;
          cur_dir_d = nxt_dir_q;
        end
      end
      default: begin
        phase_d = PH_ALLRED;
      end
    endcase
    if (phase_d != phase_q) begin
      cnt_d = '0;
    end
  end

  // Unknown phase encodings decode to all-red so no approach is ever released by a corrupt state.
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
      always_comb begin
        bus.L[2*gi +: 2] = LT_RED;
        if (cur_oh[gi]) begin
          if (phase_q == PH_GREEN) begin
            bus.L[2*gi +: 2] = LT_GREEN;
          end else if (phase_q == PH_YELLOW) begin
            bus.L[2*gi +: 2] = LT_YELLOW;
          end
        end
      end
    end
  endgenerate

  assign bus.cur_dir = cur_dir_q;
  assign bus.phase   = phase_q;
endmodule

// File: tb/tb_tl_cntr_param.sv
// Directed bench for tl_cntr_param with NUM_DIR=4: a cycle-by-cycle vector table plus reset corner cases.
module tb_tl_cntr_param;
  localparam logic [7:0] G0 = 8'b10_10_10_00;
  localparam logic [7:0] Y0 = 8'b10_10_10_01;
  localparam logic [7:0] G1 = 8'b10_10_00_10;
  localparam logic [7:0] Y1 = 8'b10_10_01_10;
  localparam logic [7:0] G2 = 8'b10_00_10_10;
  localparam logic [7:0] Y2 = 8'b10_01_10_10;
  localparam logic [7:0] G3 = 8'b00_10_10_10;
  localparam logic [7:0] Y3 = 8'b01_10_10_10;
  localparam logic [7:0] RR = 8'b10_10_10_10;
  localparam logic [1:0] PG = 2'b00;
  localparam logic [1:0] PY = 2'b01;
  localparam logic [1:0] PA = 2'b10;

  typedef struct {
    logic [3:0] t;
    logic [7:0] l;
    logic [1:0] ph;
    logic [2:0] cur;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vq[$];

  tl_cntr_param_if #(.NUM_DIR(4)) bus ();

  tl_cntr_param #(
    .NUM_DIR(4), .GREEN_MIN(3), .GREEN_MAX(6),
    .YELLOW_CYC(2), .ALLRED_CYC(1), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic add(input logic [3:0] t, input logic [7:0] l, input logic [1:0] ph,
                     input logic [2:0] cur, input int n);
    for (int i = 0; i < n; i++) begin
      vq.push_back('{t, l, ph, cur});
    end
  endtask

  task automatic check(input string name, input logic [7:0] el, input logic [1:0] ep,
                       input logic [2:0] ec);
    int nonred;
    total++;
    if (bus.L !== el || bus.phase !== ep || bus.cur_dir !== ec) begin
      bad++;
      $display("FAIL %s: got L=%b phase=%b cur_dir=%0d, want L=%b phase=%b cur_dir=%0d",
               name, bus.L, bus.phase, bus.cur_dir, el, ep, ec);
    end else begin
      $display("ok   %s: T=%b L=%b phase=%b cur_dir=%0d", name, bus.T, bus.L, bus.phase, bus.cur_dir);
    end
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.L[2*i +: 2] != 2'b10) nonred++;
    end
    total++;
    if (nonred > 1) begin
      bad++;
      $display("FAIL %s exclusive: got %0d non-red directions, want at most 1", name, nonred);
    end
  endtask

  task automatic check_cnt(input string name);
    total++;
    if (dut.cnt_q !== 8'd0) begin
      bad++;
      $display("FAIL %s cnt: got %0d, want 0", name, dut.cnt_q);
    end else begin
      $display("ok   %s cnt: 0", name);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    bus.T   = 4'b0000;

    // Idle: no demand anywhere keeps direction 0 green indefinitely.
    do_reset();
    check_cnt("reset");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle%0d", i), G0, PG, 3'd0);
      step();
    end

    // Single request, round-robin skip, wrap-around, dropped request, GREEN_MAX cap, no-demand hold.
    add(4'b0100, G0, PG, 3'd0, 3);
    add(4'b0100, Y0, PY, 3'd0, 2);
    add(4'b0100, RR, PA, 3'd0, 1);
    add(4'b1011, G2, PG, 3'd2, 3);
    add(4'b1011, Y2, PY, 3'd2, 2);
    add(4'b1011, RR, PA, 3'd2, 1);
    add(4'b0001, G3, PG, 3'd3, 3);
    add(4'b0000, Y3, PY, 3'd3, 2);
    add(4'b0000, RR, PA, 3'd3, 1);
    add(4'b0010, G0, PG, 3'd0, 3);
    add(4'b0011, Y0, PY, 3'd0, 2);
    add(4'b0011, RR, PA, 3'd0, 1);
    add(4'b0011, G1, PG, 3'd1, 6);
    add(4'b0011, Y1, PY, 3'd1, 2);
    add(4'b0011, RR, PA, 3'd1, 1);
    add(4'b0011, G0, PG, 3'd0, 6);
    add(4'b0011, Y0, PY, 3'd0, 2);
    add(4'b0011, RR, PA, 3'd0, 1);
    add(4'b0011, G1, PG, 3'd1, 1);
    add(4'b0010, G1, PG, 3'd1, 4);
    add(4'b0000, G1, PG, 3'd1, 3);

    do_reset();
    foreach (vq[i]) begin
      bus.T = vq[i].t;
      check($sformatf("vec%0d", i), vq[i].l, vq[i].ph, vq[i].cur);
      step();
    end

    // Reset in the second yellow cycle aborts the phase; reset also overrides T=1111.
    bus.T = 4'b0100;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ry_green%0d", i), G0, PG, 3'd0);
      step();
    end
    check("ry_yel1", Y0, PY, 3'd0);
    step();
    bus.T = 4'b1111;
    check("ry_yel2", Y0, PY, 3'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ry_after", G0, PG, 3'd0);
    check_cnt("ry_after");

    // Reset during all-red also returns straight to direction 0 green.
    bus.T = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ra_green%0d", i), G0, PG, 3'd0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ra_yel%0d", i), Y0, PY, 3'd0);
      step();
    end
    check("ra_allred", RR, PA, 3'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ra_after", G0, PG, 3'd0);
    check_cnt("ra_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tl_cntr_param.md
TL_CNTR_PARAM -- requirements
Module: tl_cntr_param

Interface
REQ-001 Parameter NUM_DIR, default 4: number of approach directions, legal 2..8.
REQ-002 Parameter GREEN_MIN, default 3: minimum green dwell in cycles, >=1.
REQ-003 Parameter GREEN_MAX, default 6: green dwell cap under competing demand, >=GREEN_MIN.
REQ-004 Parameter YELLOW_CYC, default 2: yellow dwell in cycles, >=1.
REQ-005 Parameter ALLRED_CYC, default 1: all-red clearance in cycles, >=1.
REQ-006 Parameter CNT_W, default 8: dwell counter width; every timing parameter SHALL fit in CNT_W bits.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  clock, all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 T  input  NUM_DIR  traffic sensor per direction, 1 = vehicle waiting or present.
REQ-011 L  output  2*NUM_DIR  light per direction; L[2i+1:2i] is direction i; 00 green, 01 yellow, 10 red, 11 never driven.
REQ-012 cur_dir  output  3  index of the direction currently owning the right of way.
REQ-013 phase  output  2  current phase; 00 GREEN, 01 YELLOW, 10 ALLRED.

Function
REQ-014 The FSM SHALL have states GREEN, YELLOW, ALLRED, plus a registered cur_dir, a registered nxt_dir and a CNT_W-bit dwell counter cnt.
REQ-015 Outputs SHALL be Moore, decoded from registered state only: direction cur_dir shows green in GREEN, yellow in YELLOW; every other direction shows red; all directions show red in ALLRED.
REQ-016 cnt SHALL clear to 0 on every phase change and otherwise increment each cycle, saturating at all-ones; dwell d = cnt+1 = cycles spent in the phase including the current cycle.
REQ-017 Demand D SHALL be 1 when any T[j]=1 for j != cur_dir.
REQ-018 GREEN -> YELLOW when D=1 and d>=GREEN_MIN and (T[cur_dir]=0 or d>=GREEN_MAX); otherwise stay GREEN.
REQ-019 With D=0, GREEN SHALL persist indefinitely regardless of T[cur_dir] or cnt.
REQ-020 On the GREEN -> YELLOW edge nxt_dir SHALL latch the first j with T[j]=1, searching cur_dir+1, cur_dir+2, ... modulo NUM_DIR (round-robin, wrap past NUM_DIR-1 to 0).
REQ-021 YELLOW -> ALLRED when d=YELLOW_CYC; T changes during YELLOW SHALL NOT alter nxt_dir.
REQ-022 ALLRED -> GREEN when d=ALLRED_CYC, with cur_dir <= nxt_dir on the same edge.
REQ-023 A request dropped during YELLOW/ALLRED SHALL still receive its green (minimum GREEN_MIN cycles, then REQ-018 applies).
REQ-024 At no cycle SHALL two directions be non-red simultaneously.
REQ-025 Illegal phase encoding 11 SHALL recover to ALLRED with cnt=0 on the next edge.

Reset
REQ-026 reset=1 at a rising edge SHALL force phase=GREEN, cur_dir=0, nxt_dir=0, cnt=0, overriding any phase in progress.
REQ-027 After reset L SHALL equal direction 0 green (00), all others red (10); reset asserted mid-YELLOW or mid-ALLRED SHALL take effect on that edge without completing the phase.
REQ-028 Reset SHALL dominate all T inputs in the same cycle.

Verification (NUM_DIR=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_CYC=2, ALLRED_CYC=1)
REQ-029 Reset, T=0000 for 20 cycles -> L=10_10_10_00, phase=00, cur_dir=0 throughout.
REQ-030 Reset, then T=0100 from cycle 1 -> dir0 green 3 cycles, yellow 2, all-red 1, then dir2 green; cur_dir=2.
REQ-031 cur_dir=2 green, T=1011 held -> dir2 leaves after 3 cycles (T[2]=0), nxt_dir=3 (round-robin, not 0).
REQ-032 cur_dir=0 green, T=0011 held -> dir0 stays green exactly 6 cycles (GREEN_MAX), then yellow, then dir1.
REQ-033 cur_dir=3, T=0001 -> nxt_dir wraps to 0; T cleared during YELLOW -> dir0 still gets 3 green cycles.
REQ-034 reset pulsed in 2nd YELLOW cycle -> next cycle L=10_10_10_00, cnt=0; continuous check that at most one direction is non-red.
